// File: rtl/cpu_defs.sv
// Shared CPU definitions for the fetch front end.
// Holds the reset vector, the ADEL exception code, bus widths and the FIFO entry layout.
// Imported by the fetch interface, the fetch FIFO users and the fetch controller.
package cpu_defs;
   localparam int          XLEN     = 32;
   localparam int          AW       = 32;
   localparam logic [31:0] RESET_PC = 32'hbfc0_0000;
   localparam logic [4:0]  EXC_ADEL = 5'h04;

   // One decoded-side entry: PC, instruction word, misaligned-fetch flag
   typedef struct packed {
      logic [AW-1:0]   pc;
      logic [XLEN-1:0] inst;
      logic            adel;
   } fetch_ent_t;

   // Instruction fetches must be word aligned
   function automatic logic misaligned(input logic [AW-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction
endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Bundle of the fetch controller's PC, SRAM and decode-side handshakes.
// master = fetch controller view, slave = surrounding pipeline / SRAM view.
// Pure wiring, no timing of its own.
interface if_fetch_ctrl_if;
   import cpu_defs::*;

   logic [AW-1:0]   pc_i;
   logic            pc_valid_i;
   logic            pc_ready_o;
   logic            flush_i;
   logic            inst_req_o;
   logic [AW-1:0]   inst_addr_o;
   logic            inst_addr_ok_i;
   logic            inst_data_ok_i;
   logic [XLEN-1:0] inst_rdata_i;
   logic            id_valid_o;
   logic            id_ready_i;
   logic [AW-1:0]   id_pc_o;
   logic [XLEN-1:0] id_inst_o;
   logic            id_adel_o;

   modport master (
      input  pc_i, pc_valid_i, flush_i, inst_addr_ok_i, inst_data_ok_i, inst_rdata_i, id_ready_i,
      output pc_ready_o, inst_req_o, inst_addr_o, id_valid_o, id_pc_o, id_inst_o, id_adel_o
   );

   modport slave (
      output pc_i, pc_valid_i, flush_i, inst_addr_ok_i, inst_data_ok_i, inst_rdata_i, id_ready_i,
      input  pc_ready_o, inst_req_o, inst_addr_o, id_valid_o, id_pc_o, id_inst_o, id_adel_o
   );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous in-order FIFO with synchronous flush.
// Latency: a pushed entry is visible at head one cycle after the push.
// No internal backpressure: callers must not push when full or pop when empty.
module fetch_fifo #(
   parameter  int W     = 65,
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic [W-1:0]  push_dat,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Storage array carries no reset; validity lives in count
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_dat;
   end

   // Pointer and occupancy tracking; flush empties the queue
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= nxt(wr_ptr);
         if (pop)  rd_ptr <= nxt(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head = mem[rd_ptr];
endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-request stage: issues PCs to the instruction SRAM and buffers replies in order for decode.
// Latency: pc_ready in the request cycle; decode sees an instruction one cycle after data_ok.
// Backpressure: requests issue only when a FIFO slot is reserved; IF_FETCH_PERF_EN adds perf counters.
module if_fetch_ctrl
   import cpu_defs::*;
#(
   parameter int MAX_OUTST = 2,
   parameter int BUF_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst,
   if_fetch_ctrl_if.master     bus
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0]         perf_fetch_cnt,
   output logic [31:0]         perf_stall_cnt
`endif
);
   localparam int OW = $clog2(MAX_OUTST + 1);
   localparam int FW = $clog2(BUF_DEPTH + 1);
   // Room for several back-to-back redirects before their stale replies drain
   localparam int NW = 4;

   logic [OW-1:0] outst;
   logic [FW-1:0] fcnt;
   logic [NW-1:0] cancel;
   logic [AW-1:0] tag;
   fetch_ent_t    head;
   fetch_ent_t    head_g;
   fetch_ent_t    push_ent;
   logic          space, req, accept, mis_take;
   logic          resp_take, resp_drop, fifo_push, fifo_pop, tag_pop;

   // Request/accept decisions and FIFO write selection
   always_comb begin
      space     = (int'(outst) + int'(fcnt) < BUF_DEPTH) && (int'(outst) < MAX_OUTST);
      req       = rst && bus.pc_valid_i && !misaligned(bus.pc_i) && space && !bus.flush_i;
      accept    = req && bus.inst_addr_ok_i;
      // Misaligned PCs wait for all earlier fetches to land so program order holds
      mis_take  = rst && bus.pc_valid_i && misaligned(bus.pc_i) && !bus.flush_i &&
                  (outst == '0) && (int'(fcnt) < BUF_DEPTH);
      resp_drop = bus.inst_data_ok_i && (cancel != '0);
      // Stray replies (nothing outstanding) are ignored so the tag queue never underflows
      resp_take = bus.inst_data_ok_i && (cancel == '0) && (outst != '0);
      tag_pop   = resp_take && !bus.flush_i;
      fifo_push = !bus.flush_i && (resp_take || mis_take);
      fifo_pop  = (fcnt != '0) && bus.id_ready_i && !bus.flush_i;
      push_ent  = '0;
      if (resp_take) begin
         push_ent.pc   = tag;
         push_ent.inst = bus.inst_rdata_i;
         push_ent.adel = 1'b0;
      end else begin
         push_ent.pc   = bus.pc_i;
         push_ent.inst = '0;
         push_ent.adel = 1'b1;
      end
      head_g = (fcnt != '0) ? head : '0;
   end

   // Tag queue: PCs of accepted requests; its occupancy is the outstanding count
   fetch_fifo #(.W(AW), .DEPTH(MAX_OUTST)) u_tag_q (
      .clk      (clk),
      .rst      (rst),
      .flush    (bus.flush_i),
      .push     (accept),
      .push_dat (bus.pc_i),
      .pop      (tag_pop),
      .head     (tag),
      .count    (outst)
   );

   // Instruction FIFO towards decode
   fetch_fifo #(.W($bits(fetch_ent_t)), .DEPTH(BUF_DEPTH)) u_inst_q (
      .clk      (clk),
      .rst      (rst),
      .flush    (bus.flush_i),
      .push     (fifo_push),
      .push_dat (push_ent),
      .pop      (fifo_pop),
      .head     (head),
      .count    (fcnt)
   );

   // Count replies still owed for requests killed by a redirect
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cancel <= '0;
      end else if (bus.flush_i) begin
         cancel <= cancel + NW'(outst) -
                   NW'(bus.inst_data_ok_i && ((cancel != '0) || (outst != '0)));
      end else if (resp_drop) begin
         cancel <= cancel - NW'(1);
      end
   end

`ifdef IF_FETCH_PERF_EN
   // Aligned-fetch deliveries and PC-side stall cycles, free-running
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         perf_fetch_cnt <= perf_fetch_cnt + 32'(resp_take && !bus.flush_i);
         perf_stall_cnt <= perf_stall_cnt +
                           32'(bus.pc_valid_i && !bus.pc_ready_o && !bus.flush_i);
      end
   end
`endif

   assign bus.inst_req_o  = req;
   assign bus.inst_addr_o = bus.pc_i;
   assign bus.pc_ready_o  = accept || mis_take;
   assign bus.id_valid_o  = (fcnt != '0);
   assign bus.id_pc_o     = head_g.pc;
   assign bus.id_inst_o   = head_g.inst;
   assign bus.id_adel_o   = head_g.adel;
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios followed by randomized traffic.
// A queue-based SRAM model and an in-order expected-instruction scoreboard supply all expected values.
// Optional perf counters are checked when IF_FETCH_PERF_EN is defined.
module tb_if_fetch_ctrl;
   import cpu_defs::*;

   logic clk;
   logic rst;
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;

   if_fetch_ctrl_if bus ();

`ifdef IF_FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
   if_fetch_ctrl dut (.clk(clk), .rst(rst), .bus(bus),
                      .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt));
`else
   if_fetch_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: pending request addresses with earliest reply cycle
   logic [31:0] sram_a[$];
   int          sram_due[$];
   // Scoreboard: instructions decode must still receive, in program order
   fetch_ent_t  exp_q[$];
   logic [31:0] pc_reg;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
   endfunction

   task automatic idle();
      bus.pc_i           = '0;
      bus.pc_valid_i     = 1'b0;
      bus.flush_i        = 1'b0;
      bus.inst_addr_ok_i = 1'b0;
      bus.inst_data_ok_i = 1'b0;
      bus.inst_rdata_i   = '0;
      bus.id_ready_i     = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pc(input logic [31:0] pc, input logic v, input logic aok);
      bus.pc_i = pc; bus.pc_valid_i = v; bus.inst_addr_ok_i = aok;
   endtask

   task automatic resp(input logic ok, input logic [31:0] d);
      bus.inst_data_ok_i = ok; bus.inst_rdata_i = d;
   endtask

   // One randomized cycle: drive, observe, update SRAM model and scoreboard
   task automatic rand_cycle(input bit stim);
      fetch_ent_t e;
      logic [31:0] t;
      tick();
      cyc++;
      bus.flush_i        = stim && ($urandom_range(0, 39) == 0);
      bus.pc_valid_i     = stim && ($urandom_range(0, 9) < 8);
      bus.pc_i           = pc_reg;
      bus.inst_addr_ok_i = ($urandom_range(0, 3) != 0);
      bus.id_ready_i     = !stim || ($urandom_range(0, 2) != 0);
      bus.inst_data_ok_i = (sram_a.size() != 0) && (sram_due[0] <= cyc) && ($urandom_range(0, 3) != 0);
      bus.inst_rdata_i   = bus.inst_data_ok_i ? mem_f(sram_a[0]) : $urandom;
      #1;
      if (bus.inst_req_o) chk("rnd_addr", bus.inst_addr_o, bus.pc_i);
      if (bus.pc_i[1:0] != 2'b00) chk("rnd_mis_noreq", bus.inst_req_o, 0);
      if (bus.flush_i) begin
         chk("rnd_flush_rdy", bus.pc_ready_o, 0);
         chk("rnd_flush_req", bus.inst_req_o, 0);
      end
      if (bus.pc_ready_o && bus.pc_i[1:0] == 2'b00)
         chk("rnd_rdy_accept", bus.inst_req_o && bus.inst_addr_ok_i, 1);
      if (bus.inst_data_ok_i) begin
         void'(sram_a.pop_front());
         void'(sram_due.pop_front());
      end
      if (bus.inst_req_o && bus.inst_addr_ok_i) begin
         sram_a.push_back(bus.pc_i);
         sram_due.push_back(cyc + 1 + $urandom_range(0, 2));
      end
      if (bus.flush_i) begin
         exp_q.delete();
         t = $urandom & 32'h0000_fffc;
         if ($urandom_range(0, 5) == 0) t = t | 32'h2;
         pc_reg = t;
      end else begin
         if (bus.id_valid_o && bus.id_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("rnd_spurious_id", bus.id_valid_o, 0);
            end else begin
               e = exp_q.pop_front();
               chk("rnd_id_pc", bus.id_pc_o, e.pc);
               chk("rnd_id_inst", bus.id_inst_o, e.inst);
               chk("rnd_id_adel", bus.id_adel_o, e.adel);
            end
         end
         if (bus.pc_ready_o) begin
            e.pc   = bus.pc_i;
            e.adel = (bus.pc_i[1:0] != 2'b00);
            e.inst = e.adel ? 32'h0 : mem_f(bus.pc_i);
            exp_q.push_back(e);
            pc_reg = (bus.pc_i & 32'hffff_fffc) + 32'd4;
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      idle();
      #3;
      // Reset state
      chk("rst_id_valid", bus.id_valid_o, 0);
      chk("rst_inst_req", bus.inst_req_o, 0);
      chk("rst_pc_ready", bus.pc_ready_o, 0);
      chk("rst_id_pc", bus.id_pc_o, 0);
      chk("rst_id_inst", bus.id_inst_o, 0);
      chk("rst_id_adel", bus.id_adel_o, 0);
      tick();
      rst = 1'b1;

      // Single fetch, data_ok two cycles after the request
      tick();
      drive_pc(RESET_PC, 1, 1); #1;
      chk("t1_req", bus.inst_req_o, 1);
      chk("t1_rdy", bus.pc_ready_o, 1);
      chk("t1_addr", bus.inst_addr_o, RESET_PC);
      tick(); drive_pc(0, 0, 0);
      tick(); resp(1, 32'h0280_0000); #1;
      chk("t1_no_comb_path", bus.id_valid_o, 0);
      tick(); resp(0, 0); #1;
      chk("t1_valid", bus.id_valid_o, 1);
      chk("t1_pc", bus.id_pc_o, RESET_PC);
      chk("t1_inst", bus.id_inst_o, 32'h0280_0000);
      chk("t1_adel", bus.id_adel_o, 0);
`ifdef IF_FETCH_PERF_EN
      chk("t1_perf_fetch", perf_fetch_cnt, 1);
`endif
      bus.id_ready_i = 1;
      tick(); bus.id_ready_i = 0; #1;
      chk("t1_popped", bus.id_valid_o, 0);

      // Back-to-back with decode stalled
      drive_pc(32'h0, 1, 1); #1; chk("t2_rdy0", bus.pc_ready_o, 1);
      tick(); drive_pc(32'h4, 1, 1); #1; chk("t2_rdy4", bus.pc_ready_o, 1);
      tick(); drive_pc(32'h8, 1, 1); resp(1, 32'h100); #1;
      chk("t2_req8_held", bus.inst_req_o, 0);
      chk("t2_rdy8_held", bus.pc_ready_o, 0);
      tick(); resp(1, 32'h104); #1; chk("t2_rdy8_held2", bus.pc_ready_o, 0);
      tick(); resp(0, 0); #1;
      chk("t2_rdy8_full", bus.pc_ready_o, 0);
      chk("t2_head0_pc", bus.id_pc_o, 32'h0);
      chk("t2_head0_inst", bus.id_inst_o, 32'h100);
      bus.id_ready_i = 1;
      tick(); #1;
      chk("t2_head4_pc", bus.id_pc_o, 32'h4);
      chk("t2_head4_inst", bus.id_inst_o, 32'h104);
      chk("t2_req8", bus.inst_req_o, 1);
      chk("t2_addr8", bus.inst_addr_o, 32'h8);
      tick(); drive_pc(0, 0, 0); bus.id_ready_i = 0; resp(1, 32'h108); #1;
      chk("t2_empty", bus.id_valid_o, 0);
      tick(); resp(0, 0); #1;
      chk("t2_head8_pc", bus.id_pc_o, 32'h8);
      bus.id_ready_i = 1;
      tick(); bus.id_ready_i = 0;

      // Flush with two outstanding
      drive_pc(32'h10, 1, 1);
      tick(); drive_pc(32'h14, 1, 1);
      tick(); drive_pc(32'hbfc0_0100, 1, 1); bus.flush_i = 1; #1;
      chk("t3_flush_req", bus.inst_req_o, 0);
      chk("t3_flush_rdy", bus.pc_ready_o, 0);
      tick(); bus.flush_i = 0; drive_pc(0, 0, 0); resp(1, 32'h0000_aaaa);
      tick(); resp(1, 32'h0000_bbbb);
      tick(); resp(0, 0); drive_pc(32'hbfc0_0100, 1, 1); #1;
      chk("t3_dropped", bus.id_valid_o, 0);
      chk("t3_new_rdy", bus.pc_ready_o, 1);
      tick(); drive_pc(0, 0, 0); resp(1, 32'h0000_cccc);
      tick(); resp(0, 0); #1;
      chk("t3_valid", bus.id_valid_o, 1);
      chk("t3_pc", bus.id_pc_o, 32'hbfc0_0100);
      chk("t3_inst", bus.id_inst_o, 32'h0000_cccc);
      bus.id_ready_i = 1;
      tick(); bus.id_ready_i = 0; #1;
      chk("t3_only_one", bus.id_valid_o, 0);

      // Misaligned PC with nothing outstanding
      drive_pc(32'hbfc0_0002, 1, 1); #1;
      chk("t4_noreq", bus.inst_req_o, 0);
      chk("t4_rdy", bus.pc_ready_o, 1);
      tick(); drive_pc(0, 0, 0); #1;
      chk("t4_valid", bus.id_valid_o, 1);
      chk("t4_adel", bus.id_adel_o, 1);
      chk("t4_inst", bus.id_inst_o, 0);
      chk("t4_pc", bus.id_pc_o, 32'hbfc0_0002);
      bus.id_ready_i = 1;
      tick(); bus.id_ready_i = 0;

      // Misaligned PC behind an outstanding fetch
      drive_pc(32'h20, 1, 1);
      tick(); drive_pc(32'h26, 1, 1); #1; chk("t5_held", bus.pc_ready_o, 0);
      tick(); resp(1, 32'h120); #1; chk("t5_held_resp", bus.pc_ready_o, 0);
      tick(); resp(0, 0); #1; chk("t5_rdy", bus.pc_ready_o, 1);
      tick(); drive_pc(0, 0, 0); bus.id_ready_i = 1; #1;
      chk("t5_first_pc", bus.id_pc_o, 32'h20);
      chk("t5_first_inst", bus.id_inst_o, 32'h120);
      tick(); #1;
      chk("t5_second_pc", bus.id_pc_o, 32'h26);
      chk("t5_second_adel", bus.id_adel_o, 1);
      tick(); bus.id_ready_i = 0; #1;
      chk("t5_empty", bus.id_valid_o, 0);

      // Async reset mid-flight (outst=1, fcnt=1)
      drive_pc(32'h30, 1, 1);
      tick(); drive_pc(32'h34, 1, 1); resp(1, 32'h130);
      tick(); drive_pc(32'h38, 1, 1); resp(0, 0); #1;
      chk("t6_pre_valid", bus.id_valid_o, 1);
      #2; rst = 1'b0; #1;
      chk("t6_rst_valid", bus.id_valid_o, 0);
      chk("t6_rst_req", bus.inst_req_o, 0);
      chk("t6_rst_rdy", bus.pc_ready_o, 0);
`ifdef IF_FETCH_PERF_EN
      chk("t6_perf_fetch", perf_fetch_cnt, 0);
      chk("t6_perf_stall", perf_stall_cnt, 0);
`endif
      idle();
      tick(); rst = 1'b1;

      // Randomized traffic against the scoreboard, then drain
      pc_reg = RESET_PC;
      for (int c = 0; c < 3000; c++) rand_cycle(1);
      for (int k = 0; k < 300 && (exp_q.size() != 0 || sram_a.size() != 0); k++) rand_cycle(0);
      chk("drain_exp", exp_q.size(), 0);
      chk("drain_sram", sram_a.size(), 0);
      tick(); #1;
      chk("drain_id_valid", bus.id_valid_o, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
